// File: rtl/fpu_issue_ctrl.sv
// FPU request initiator: accepts one op from decode, issues it to the FPU with a
// single-cycle enable, waits for the result (with a watchdog) and presents the
// tagged, normalised result to register writeback.
module fpu_issue_ctrl #(
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // decode-side request
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [4:0]       i_req_ctl,
  input  logic [31:0]      i_req_x1,
  input  logic [31:0]      i_req_x2,
  input  logic [TAG_W-1:0] i_req_tag,
  // FPU request/response
  output logic [4:0]       o_fpu_ctl,
  output logic [31:0]      o_fpu_x1,
  output logic [31:0]      o_fpu_x2,
  output logic             o_fpu_en,
  input  logic [31:0]      i_fpu_y,
  input  logic             i_fpu_ready,
  // writeback
  output logic             o_wb_valid,
  input  logic             i_wb_ack,
  output logic [31:0]      o_wb_data,
  output logic [TAG_W-1:0] o_wb_tag,
  output logic             o_wb_is_int,
  output logic             o_wb_err,
  output logic             o_timeout_err
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
  localparam logic [4:0] LastOp     = 5'd20;
  localparam logic [4:0] OpFtoi     = 5'd6;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_t;

  state_t             r_state, w_state_next;
  logic [4:0]         r_ctl, w_ctl_next;
  logic [31:0]        r_x1, w_x1_next;
  logic [31:0]        r_x2, w_x2_next;
  logic [TAG_W-1:0]   r_tag, w_tag_next;
  logic [7:0]         r_cnt, w_cnt_next;
  logic [31:0]        r_wb_data, w_wb_data_next;
  logic               r_wb_is_int, w_wb_is_int_next;
  logic               r_wb_err, w_wb_err_next;
  logic               r_timeout_err, w_timeout_err_next;
  logic [7:0]         w_cnt_inc;
  logic               w_is_cmp;

  // Compare ops return a boolean in bit 0 that goes to the integer register file.
  always_comb begin
    w_is_cmp = 1'b0;
    case (r_ctl)
      5'd9, 5'd10, 5'd13, 5'd16, 5'd17, 5'd18: w_is_cmp = 1'b1;
      default:                                 w_is_cmp = 1'b0;
    endcase
  end

  // Saturating increment so a huge TIMEOUT can never wrap the counter.
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  // Next-state and captured-data logic.
  always_comb begin
    w_state_next       = r_state;
    w_ctl_next         = r_ctl;
    w_x1_next          = r_x1;
    w_x2_next          = r_x2;
    w_tag_next         = r_tag;
    w_cnt_next         = r_cnt;
    w_wb_data_next     = r_wb_data;
    w_wb_is_int_next   = r_wb_is_int;
    w_wb_err_next      = r_wb_err;
    w_timeout_err_next = r_timeout_err;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_ctl_next = i_req_ctl;
          w_x1_next  = i_req_x1;
          w_x2_next  = i_req_x2;
          w_tag_next = i_req_tag;
          if (i_req_ctl <= LastOp) begin
            w_state_next = StIssue;
          end else begin
            // Unknown op code: never reaches the FPU, reported as an error result.
            w_wb_data_next   = 32'd0;
            w_wb_is_int_next = 1'b0;
            w_wb_err_next    = 1'b1;
            w_state_next     = StWb;
          end
        end
      end
      StIssue: begin
        w_cnt_next   = 8'd0;
        w_state_next = StWait;
      end
      StWait: begin
        if (i_fpu_ready) begin
          w_wb_err_next = 1'b0;
          if (w_is_cmp) begin
            w_wb_data_next   = {31'd0, i_fpu_y[0]};
            w_wb_is_int_next = 1'b1;
          end else begin
            w_wb_data_next   = i_fpu_y;
            w_wb_is_int_next = (r_ctl == OpFtoi);
          end
          w_state_next = StWb;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc >= TimeoutCnt) begin
            w_timeout_err_next = 1'b1;
            w_wb_data_next     = 32'd0;
            w_wb_is_int_next   = 1'b0;
            w_wb_err_next      = 1'b1;
            w_state_next       = StWb;
          end
        end
      end
      StWb: begin
        if (i_wb_ack) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Captured operands, wait counter and writeback result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctl         <= 5'd0;
      r_x1          <= 32'd0;
      r_x2          <= 32'd0;
      r_tag         <= '0;
      r_cnt         <= 8'd0;
      r_wb_data     <= 32'd0;
      r_wb_is_int   <= 1'b0;
      r_wb_err      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ctl         <= w_ctl_next;
      r_x1          <= w_x1_next;
      r_x2          <= w_x2_next;
      r_tag         <= w_tag_next;
      r_cnt         <= w_cnt_next;
      r_wb_data     <= w_wb_data_next;
      r_wb_is_int   <= w_wb_is_int_next;
      r_wb_err      <= w_wb_err_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  assign o_req_ready   = (r_state == StIdle);
  assign o_fpu_en      = (r_state == StIssue);
  assign o_fpu_ctl     = r_ctl;
  assign o_fpu_x1      = r_x1;
  assign o_fpu_x2      = r_x2;
  assign o_wb_valid    = (r_state == StWb);
  assign o_wb_data     = r_wb_data;
  assign o_wb_tag      = r_tag;
  assign o_wb_is_int   = r_wb_is_int;
  assign o_wb_err      = r_wb_err;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: table of ops with an FPU response model,
// expected writebacks queued at issue and compared when wb_valid appears.
module tb_fpu_issue_ctrl;

  localparam int TO = 4;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_ctl;
  logic [31:0] req_x1, req_x2;
  logic [5:0]  req_tag;
  logic [4:0]  fpu_ctl;
  logic [31:0] fpu_x1, fpu_x2, fpu_y;
  logic        fpu_en, fpu_ready;
  logic        wb_valid, wb_ack, wb_is_int, wb_err, timeout_err;
  logic [31:0] wb_data;
  logic [5:0]  wb_tag;

  fpu_issue_ctrl #(.TAG_W(6), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_ctl(req_ctl),
    .i_req_x1(req_x1), .i_req_x2(req_x2), .i_req_tag(req_tag),
    .o_fpu_ctl(fpu_ctl), .o_fpu_x1(fpu_x1), .o_fpu_x2(fpu_x2), .o_fpu_en(fpu_en),
    .i_fpu_y(fpu_y), .i_fpu_ready(fpu_ready),
    .o_wb_valid(wb_valid), .i_wb_ack(wb_ack), .o_wb_data(wb_data), .o_wb_tag(wb_tag),
    .o_wb_is_int(wb_is_int), .o_wb_err(wb_err), .o_timeout_err(timeout_err)
  );

  typedef struct {
    string       name;
    logic [4:0]  ctl;
    logic [31:0] x1, x2;
    logic [5:0]  tag;
    logic [31:0] y;        // FPU model response
    int          lat;      // cycles after en before fpu_ready; -1 = never
    int          ack_dly;  // cycles wb_ack is withheld
    logic [31:0] data;
    logic        is_int, err, to;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [5:0]  tag;
    logic        is_int, err, to, chk_int;
    int          lat, en;
  } exp_t;

  vec_t vecs[$];
  exp_t q_exp[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, acc_cyc = 0, en_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and issue-pulse counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fpu_en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [4:0] ctl, input logic [31:0] x1, x2,
                         input logic [5:0] tag, input logic [31:0] y, input int lat,
                         input int ack_dly, input logic [31:0] data, input logic is_int, err,
                         to);
    vec_t v;
    v.name = name; v.ctl = ctl; v.x1 = x1; v.x2 = x2; v.tag = tag; v.y = y; v.lat = lat;
    v.ack_dly = ack_dly; v.data = data; v.is_int = is_int; v.err = err; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic drive_req(input logic [4:0] ctl, input logic [31:0] x1, x2,
                           input logic [5:0] tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_ctl = ctl; req_x1 = x1; req_x2 = x2; req_tag = tag;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_en();
    int n = 0;
    @(negedge clk);
    while (!fpu_en && n < 8) begin @(negedge clk); n++; end
    chk("fpu_en_seen", {31'd0, fpu_en}, 32'd1);
  endtask

  task automatic wait_wb(output int obs_lat);
    int n = 0;
    while (!wb_valid && n < 20) begin @(negedge clk); n++; end
    chk("wb_valid_seen", {31'd0, wb_valid}, 32'd1);
    obs_lat = cyc - acc_cyc + 1;
  endtask

  task automatic pulse_ready(input logic [31:0] y);
    @(posedge clk); #1;
    fpu_y = y; fpu_ready = 1'b1;
    @(posedge clk); #1;
    fpu_ready = 1'b0; fpu_y = 32'd0;
  endtask

  task automatic cmp_wb(input exp_t e, input int obs_lat, input int en_delta);
    chk({e.name, ":wb_data"}, wb_data, e.data);
    chk({e.name, ":wb_tag"}, {26'd0, wb_tag}, {26'd0, e.tag});
    chk({e.name, ":wb_err"}, {31'd0, wb_err}, {31'd0, e.err});
    if (e.chk_int) chk({e.name, ":wb_is_int"}, {31'd0, wb_is_int}, {31'd0, e.is_int});
    chk({e.name, ":timeout_err"}, {31'd0, timeout_err}, {31'd0, e.to});
    chk({e.name, ":latency"}, obs_lat, e.lat);
    chk({e.name, ":en_pulses"}, en_delta, e.en);
  endtask

  task automatic ack_wb(input exp_t e, input int ack_dly);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk({e.name, ":hold_valid"}, {31'd0, wb_valid}, 32'd1);
      chk({e.name, ":hold_req_ready"}, {31'd0, req_ready}, 32'd0);
      chk({e.name, ":hold_data"}, wb_data, e.data);
      chk({e.name, ":hold_tag"}, {26'd0, wb_tag}, {26'd0, e.tag});
    end
    @(negedge clk);
    wb_ack = 1'b1;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    @(negedge clk);
    chk({e.name, ":ready_after_ack"}, {31'd0, req_ready}, 32'd1);
    chk({e.name, ":valid_after_ack"}, {31'd0, wb_valid}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   en0, obs;
    en0 = en_cnt;
    e.name = v.name; e.data = v.data; e.tag = v.tag; e.is_int = v.is_int; e.err = v.err;
    e.to = v.to;
    e.en = (v.ctl <= 5'd20) ? 1 : 0;
    e.lat = (e.en == 0) ? 1 : (v.lat < 0) ? TO + 2 : v.lat + 2;
    e.chk_int = !(v.lat < 0 && e.en == 1);
    q_exp.push_back(e);
    drive_req(v.ctl, v.x1, v.x2, v.tag);
    if (e.en == 1) begin
      wait_en();
      chk({v.name, ":fpu_ctl"}, {27'd0, fpu_ctl}, {27'd0, v.ctl});
      chk({v.name, ":fpu_x1"}, fpu_x1, v.x1);
      chk({v.name, ":fpu_x2"}, fpu_x2, v.x2);
      if (v.lat >= 0) begin
        repeat (v.lat) @(posedge clk);
        #1 fpu_y = v.y; fpu_ready = 1'b1;
        @(posedge clk); #1;
        fpu_ready = 1'b0; fpu_y = 32'd0;
      end
    end
    wait_wb(obs);
    e = q_exp.pop_front();
    cmp_wb(e, obs, en_cnt - en0);
    ack_wb(e, v.ack_dly);
  endtask

  initial begin
    exp_t e;
    vec_t v;
    int   obs, en0;

    rst = 1'b0; req_valid = 1'b0; req_ctl = 5'd0; req_x1 = 32'd0; req_x2 = 32'd0;
    req_tag = 6'd0; fpu_y = 32'd0; fpu_ready = 1'b0; wb_ack = 1'b0;

    //   name      ctl    x1            x2            tag    y             lat ack data          int err to
    add_vec("fadd",   5'd0,  32'h3F800000, 32'h40000000, 6'd5,  32'h40400000, 2, 0, 32'h40400000, 0, 0, 0);
    add_vec("feq",    5'd9,  32'h11111111, 32'h11111111, 6'd7,  32'hFFFFFFFF, 1, 0, 32'h00000001, 1, 0, 0);
    add_vec("fisneg", 5'd18, 32'h3F000000, 32'h0,        6'd8,  32'h00000000, 3, 1, 32'h00000000, 1, 0, 0);
    add_vec("fle",    5'd10, 32'h40000000, 32'h3F800000, 6'd9,  32'hFFFFFFFE, 1, 0, 32'h00000000, 1, 0, 0);
    add_vec("ftoi",   5'd6,  32'hC0400000, 32'h0,        6'd10, 32'hFFFFFFFD, 2, 0, 32'hFFFFFFFD, 1, 0, 0);
    add_vec("fmul",   5'd2,  32'h12345678, 32'h9ABCDEF0, 6'd63, 32'h12345679, 2, 0, 32'h12345679, 0, 0, 0);
    add_vec("ill25",  5'd25, 32'hAAAA5555, 32'h5555AAAA, 6'd3,  32'h0,        0, 0, 32'h00000000, 0, 1, 0);
    add_vec("ill21",  5'd21, 32'h1,        32'h2,        6'd0,  32'h0,        0, 2, 32'h00000000, 0, 1, 0);
    add_vec("fsqr",   5'd20, 32'h40400000, 32'h0,        6'd33, 32'hABCDEF01, 1, 0, 32'hABCDEF01, 0, 0, 0);
    add_vec("tmo",    5'd4,  32'h3F800000, 32'h0,        6'd12, 32'h0,       -1, 0, 32'h00000000, 0, 1, 1);
    add_vec("fmax",   5'd15, 32'h7F7FFFFF, 32'h0,        6'd13, 32'h7F7FFFFF, 3, 0, 32'h7F7FFFFF, 0, 0, 1);
    add_vec("fsub_bp",5'd1,  32'h40400000, 32'h3F800000, 6'd14, 32'h40000000, 2, 5, 32'h40000000, 0, 0, 1);

    // Asynchronous reset: outputs must clear before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst:req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst:fpu_en", {31'd0, fpu_en}, 32'd0);
    chk("rst:wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst:wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst:wb_is_int", {31'd0, wb_is_int}, 32'd0);
    chk("rst:timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst:fpu_ctl", {27'd0, fpu_ctl}, 32'd0);
    chk("rst:fpu_x1", fpu_x1, 32'd0);
    chk("rst:fpu_x2", fpu_x2, 32'd0);
    chk("rst:wb_data", wb_data, 32'd0);
    chk("rst:wb_tag", {26'd0, wb_tag}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Timeout, then a late response during WB and another in IDLE must be dropped.
    e.name = "tmo_late"; e.data = 32'd0; e.tag = 6'd21; e.is_int = 1'b0; e.err = 1'b1;
    e.to = 1'b1; e.chk_int = 1'b0; e.lat = TO + 2; e.en = 1;
    q_exp.push_back(e);
    en0 = en_cnt;
    drive_req(5'd4, 32'h1234, 32'h5678, 6'd21);
    wait_en();
    wait_wb(obs);
    e = q_exp.pop_front();
    cmp_wb(e, obs, en_cnt - en0);
    @(posedge clk); #1 fpu_y = 32'hDEADBEEF; fpu_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 fpu_ready = 1'b0;
    @(negedge clk);
    chk("late_in_wb:data", wb_data, 32'd0);
    chk("late_in_wb:err", {31'd0, wb_err}, 32'd1);
    chk("late_in_wb:valid", {31'd0, wb_valid}, 32'd1);
    ack_wb(e, 0);
    pulse_ready(32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_in_idle:wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("late_in_idle:req_ready", {31'd0, req_ready}, 32'd1);
    end

    // Reset mid-WAIT aborts the op; its late response is ignored afterwards.
    drive_req(5'd1, 32'h40A00000, 32'h3F800000, 6'd30);
    wait_en();
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("abort:wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("abort:req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort:fpu_en", {31'd0, fpu_en}, 32'd0);
    chk("abort:fpu_ctl", {27'd0, fpu_ctl}, 32'd0);
    chk("abort:fpu_x1", fpu_x1, 32'd0);
    chk("abort:timeout_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_ready(32'h40800000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort:no_wb_valid", {31'd0, wb_valid}, 32'd0);
    end
    v.name = "fsub_after_rst"; v.ctl = 5'd1; v.x1 = 32'h40A00000; v.x2 = 32'h3F800000;
    v.tag = 6'd30; v.y = 32'h40800000; v.lat = 2; v.ack_dly = 0; v.data = 32'h40800000;
    v.is_int = 1'b0; v.err = 1'b0; v.to = 1'b0;
    run_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
